// File: rtl/famicom_bus_pkg.sv
// Shared types and constants for the Famicom CPU bus master.
//   bus_state_e : controller state (init wait, idle M2 cycle, active M2 cycle)
//   IDLE_ADDR   : address presented on the bus during idle M2 cycles
package famicom_bus_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE
  } bus_state_e;

  localparam logic [15:0] IDLE_ADDR = 16'h0000;

endpackage

// File: rtl/famicom_cpu_bus_master_m2_phase_gen.sv
// Free-running M2 clock generator.
// M2 is low for HALF_CYCLES clks, then high for HALF_CYCLES clks, forever.
//   clk, rst_n  : system clock, async active-low reset (M2 held low)
//   m2          : M2 clock to the cartridge
//   low_start   : first clk of a low phase (true during the first clk after reset)
//   high_start  : first clk of a high phase
//   fall_strobe : last clk of a high phase; M2 drops on the edge that ends it
module m2_phase_gen #(
  parameter int unsigned HALF_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic m2,
  output logic low_start,
  output logic high_start,
  output logic fall_strobe
);

  localparam int unsigned CntW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HALF_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            m2_q, m2_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    m2_d  = m2_q;
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      m2_d  = ~m2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      m2_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      m2_q  <= m2_d;
    end
  end

  assign m2          = m2_q;
  assign low_start   = ~m2_q & (cnt_q == '0);
  assign high_start  = m2_q & (cnt_q == '0);
  assign fall_strobe = m2_q & (cnt_q == CntLast);

endmodule

// File: rtl/famicom_cpu_bus_master.sv
// Console-side initiator for the Famicom/NES cartridge CPU bus.
// Requests are captured into a one-entry slot and issued as whole M2 cycles.
//   clk, rst_n             : system clock, async active-low reset
//   req/req_rw/req_addr/
//   req_wdata, ready       : request handshake (accepted when req & ready)
//   rsp_valid, rsp_rdata   : one-clk completion pulse at M2 fall, read data
//   m2, romsel, cpu_rw,
//   cpu_addr               : cartridge CPU bus control and address (A0-A14)
//   cpu_data_out/_oe/_in   : cartridge data bus, split for a tristate pad
module famicom_cpu_bus_master
  import famicom_bus_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 3,
  parameter int unsigned INIT_CYCLES = 16,
  parameter int unsigned DATA_HOLD   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in
);

  localparam int unsigned InitW = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int unsigned HoldW = $clog2(HALF_CYCLES + 1);

  logic low_start, high_start, fall_strobe;

  m2_phase_gen #(
    .HALF_CYCLES(HALF_CYCLES)
  ) u_m2_phase_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .m2         (m2),
    .low_start  (low_start),
    .high_start (high_start),
    .fall_strobe(fall_strobe)
  );

  // Transactions are launched on the edge that ends fall_strobe, which is the
  // edge that begins low_start, so the phase-start strobes are not needed here.
  logic unused_strobes;
  assign unused_strobes = low_start ^ high_start;

  bus_state_e       state_q, state_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;

  logic             slot_full_q, slot_full_d;
  logic             slot_rw_q, slot_rw_d;
  logic [15:0]      slot_addr_q, slot_addr_d;
  logic [7:0]       slot_wdata_q, slot_wdata_d;

  logic             act_rw_q, act_rw_d;
  logic [15:0]      act_addr_q, act_addr_d;
  logic [7:0]       act_wdata_q, act_wdata_d;

  // Write-data hold after M2 falls; kept apart from the active registers so a
  // back-to-back transaction can load its address while old data is still held.
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [14:0]      hold_addr_q, hold_addr_d;
  logic [7:0]       hold_wdata_q, hold_wdata_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;

  logic accept;

  assign ready  = (state_q != ST_INIT) & ~slot_full_q;
  assign accept = req & ready;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    slot_full_d  = slot_full_q;
    slot_rw_d    = slot_rw_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    act_rw_d     = act_rw_q;
    act_addr_d   = act_addr_q;
    act_wdata_d  = act_wdata_q;
    hold_cnt_d   = hold_cnt_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;

    // Slot is empty whenever accept is possible, so this never races the issue below.
    if (accept) begin
      slot_full_d  = 1'b1;
      slot_rw_d    = req_rw;
      slot_addr_d  = req_addr;
      slot_wdata_d = req_wdata;
    end

    if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HoldW'(1);
    end

    unique case (state_q)
      ST_INIT: begin
        if (fall_strobe && (init_cnt_q != '0)) begin
          init_cnt_d = init_cnt_q - InitW'(1);
        end
        if ((init_cnt_q == '0) || (fall_strobe && (init_cnt_q == InitW'(1)))) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        if (fall_strobe) begin
          if (state_q == ST_ACTIVE) begin
            rsp_valid_d = 1'b1;
            if (act_rw_q) begin
              rsp_rdata_d = cpu_data_in;
            end else begin
              hold_cnt_d   = HoldW'(DATA_HOLD);
              hold_addr_d  = act_addr_q[14:0];
              hold_wdata_d = act_wdata_q;
            end
          end
          if (slot_full_q) begin
            slot_full_d = 1'b0;
            act_rw_d    = slot_rw_q;
            act_addr_d  = slot_addr_q;
            act_wdata_d = slot_wdata_q;
            state_d     = ST_ACTIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= InitW'(INIT_CYCLES);
      slot_full_q  <= 1'b0;
      slot_rw_q    <= 1'b1;
      slot_addr_q  <= IDLE_ADDR;
      slot_wdata_q <= '0;
      act_rw_q     <= 1'b1;
      act_addr_q   <= IDLE_ADDR;
      act_wdata_q  <= '0;
      hold_cnt_q   <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      slot_full_q  <= slot_full_d;
      slot_rw_q    <= slot_rw_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      act_rw_q     <= act_rw_d;
      act_addr_q   <= act_addr_d;
      act_wdata_q  <= act_wdata_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // Bus pins: hold data first, then an active cycle overrides address and R/W.
  // During a hold clk that overlaps a new read's low phase the cart is not yet
  // driving (it only drives while M2 is high), so the overlap is harmless.
  always_comb begin
    cpu_addr     = IDLE_ADDR[14:0];
    cpu_rw       = 1'b1;
    romsel       = 1'b1;
    cpu_data_oe  = 1'b0;
    cpu_data_out = '0;
    if (hold_cnt_q != '0) begin
      cpu_addr     = hold_addr_q;
      cpu_rw       = 1'b0;
      cpu_data_oe  = 1'b1;
      cpu_data_out = hold_wdata_q;
    end
    if (state_q == ST_ACTIVE) begin
      cpu_addr = act_addr_q[14:0];
      cpu_rw   = act_rw_q;
      if (m2) begin
        romsel = ~act_addr_q[15];
        if (!act_rw_q) begin
          cpu_data_oe  = 1'b1;
          cpu_data_out = act_wdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
module tb_famicom_cpu_bus_master;

  localparam int unsigned HALF = 3;
  localparam int unsigned INIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        req_rw = 1'b1;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        ready, rsp_valid, m2, romsel, cpu_rw, cpu_data_oe;
  logic [7:0]  rsp_rdata, cpu_data_out, cpu_data_in;
  logic [14:0] cpu_addr;

  // Cart model: fixed byte, or a ROM whose byte is C0 | A[3:0].
  logic        rom_mode = 1'b0;
  logic [7:0]  fixed_data = '0;
  assign cpu_data_in = rom_mode ? {4'hC, cpu_addr[3:0]} : fixed_data;

  famicom_cpu_bus_master #(
    .HALF_CYCLES(HALF),
    .INIT_CYCLES(INIT),
    .DATA_HOLD  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ready       (ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .m2          (m2),
    .romsel      (romsel),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_data_out(cpu_data_out),
    .cpu_data_oe (cpu_data_oe),
    .cpu_data_in (cpu_data_in)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard of expected rsp_rdata values, one per issued request.
  logic [7:0] exp_q[$];
  int         rsp_times[$];
  int         cyc = 0;
  logic       prev_m2 = 1'b0;
  int         run_len = 0;
  bit         run_valid = 1'b0;
  int         m2_viol = 0;
  int         m2_runs = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_m2   <= 1'b0;
      run_len   <= 0;
      run_valid <= 1'b0;
    end else begin
      if (rsp_valid) begin
        check("rsp_at_m2_fall", {62'd0, prev_m2, m2}, 64'd2);
        if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
        else check("rsp_rdata", {56'd0, rsp_rdata}, {56'd0, exp_q.pop_front()});
        rsp_times.push_back(cyc);
      end
      if (m2 !== prev_m2) begin
        if (run_valid) begin
          m2_runs <= m2_runs + 1;
          if (run_len != HALF) m2_viol <= m2_viol + 1;
        end
        run_valid <= 1'b1;
        run_len   <= 1;
      end else begin
        run_len <= run_len + 1;
      end
      prev_m2 <= m2;
    end
  end

  logic [7:0] last_rd = 8'h00;

  task automatic send(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                      input logic [7:0] exp, input bit keep);
    int n = 0;
    req = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      req = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (!keep) req = 1'b0;
  endtask

  task automatic init_phase();
    int n = 0;
    int bad = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
      if (romsel !== 1'b1 || cpu_addr !== 15'h0 || cpu_rw !== 1'b1 || cpu_data_oe !== 1'b0)
        bad++;
    end
    check("init_ready_latency", 64'(n), 64'(INIT * 2 * HALF));
    check("init_idle_bus", 64'(bad), 64'd0);
  endtask

  int o_rsel, o_rsel_m2lo, o_oe, o_dbad, o_rw0, o_addr;

  task automatic observe(input int n, input logic [14:0] a, input logic [7:0] wd);
    o_rsel = 0; o_rsel_m2lo = 0; o_oe = 0; o_dbad = 0; o_rw0 = 0; o_addr = 0;
    repeat (n) begin
      @(negedge clk);
      if (!romsel) o_rsel++;
      if (!romsel && !m2) o_rsel_m2lo++;
      if (cpu_data_oe) begin
        o_oe++;
        if (cpu_data_out !== wd) o_dbad++;
      end
      if (!cpu_rw) o_rw0++;
      if (cpu_addr === a) o_addr++;
    end
  endtask

  initial begin
    int t0, n, hc, lat;
    bit seen_low, found;

    #2 rst_n = 1'b0;
    #21;
    check("reset_ctrl", {61'd0, m2, romsel, cpu_rw}, 64'd3);
    check("reset_data", {33'd0, cpu_addr, cpu_data_out, cpu_data_oe, ready, rsp_valid, rsp_rdata},
          64'd0);

    init_phase();

    // Read $8123 from a cart returning A5.
    fixed_data = 8'hA5;
    send(1'b1, 16'h8123, 8'h00, 8'hA5, 1'b0);
    last_rd = 8'hA5;
    observe(16, 15'h0123, 8'h00);
    check("rd_romsel_low_clks", 64'(o_rsel), 64'd3);
    check("rd_romsel_low_m2_low", 64'(o_rsel_m2lo), 64'd0);
    check("rd_oe_clks", 64'(o_oe), 64'd0);
    check("rd_addr_clks", 64'(o_addr), 64'd6);
    check("rd_rw0_clks", 64'(o_rw0), 64'd0);

    // Write $6000 = 3C; rsp_rdata must keep the previous read value.
    send(1'b0, 16'h6000, 8'h3C, last_rd, 1'b0);
    observe(16, 15'h6000, 8'h3C);
    check("wr_romsel_low_clks", 64'(o_rsel), 64'd0);
    check("wr_oe_clks", 64'(o_oe), 64'd4);
    check("wr_data_bad_clks", 64'(o_dbad), 64'd0);
    check("wr_rw0_clks", 64'(o_rw0), 64'd7);
    check("wr_addr_clks", 64'(o_addr), 64'd7);

    // Back-to-back reads with req held high.
    rom_mode = 1'b1;
    t0 = rsp_times.size();
    send(1'b1, 16'h8000, 8'h00, 8'hC0, 1'b1);
    send(1'b1, 16'h8001, 8'h00, 8'hC1, 1'b1);
    send(1'b1, 16'h8002, 8'h00, 8'hC2, 1'b0);
    last_rd = 8'hC2;
    repeat (20) @(negedge clk);
    check("b2b_rsp_count", 64'(rsp_times.size() - t0), 64'd3);
    if (rsp_times.size() >= t0 + 3) begin
      check("b2b_gap_1", 64'(rsp_times[t0+1] - rsp_times[t0]), 64'(2 * HALF));
      check("b2b_gap_2", 64'(rsp_times[t0+2] - rsp_times[t0+1]), 64'(2 * HALF));
    end

    // Request raised during the second clk of a high phase.
    rom_mode = 1'b0;
    fixed_data = 8'h5E;
    hc = 0; n = 0; seen_low = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (!m2) begin
        hc = 0;
        seen_low = 1'b1;
      end else if (seen_low) begin
        hc++;
      end
      if (hc == 2) break;
    end
    check("midhigh_found", 64'(hc), 64'd2);
    send(1'b1, 16'h8ABC, 8'h00, 8'h5E, 1'b0);
    last_rd = 8'h5E;
    check("midhigh_idle_addr", {49'd0, cpu_addr}, 64'd0);
    lat = 0;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("midhigh_rsp_latency", 64'(lat), 64'd7);
    @(negedge clk);

    // Reset during the high phase of a write.
    send(1'b0, 16'h8055, 8'h77, last_rd, 1'b0);
    found = 1'b0; n = 0;
    while (!found && n < 30) begin
      @(negedge clk);
      n++;
      if (cpu_data_oe && m2) found = 1'b1;
    end
    check("abort_write_high_seen", 64'(found), 64'd1);
    t0 = rsp_times.size();
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {59'd0, cpu_data_oe, romsel, m2, ready, rsp_valid}, 64'h08);
    exp_q.delete();
    #20;
    init_phase();
    check("abort_no_rsp", 64'(rsp_times.size() - t0), 64'd0);

    repeat (10) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("m2_period_viol", 64'(m2_viol), 64'd0);
    check("m2_runs_seen", 64'(m2_runs > 50), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/famicom_cpu_bus_master.md
Name: famicom_cpu_bus_master

Overview:
Console-side initiator for the Famicom/NES cartridge CPU bus. It generates a free-running M2 clock, /ROMSEL, R/W, A0-A14 and the data bus from a simple request/response handshake. It is used in the team's cart programmer/dumper and in the hardware-in-loop rig to exercise multicart mapper logic. M2 runs continuously, including after reset, so cart-side power-on counters advance; requests are slotted into whole M2 cycles.

Parameters:
HALF_CYCLES, 3, clk periods per M2 phase (low and high each); must be >=2.
INIT_CYCLES, 16, idle M2 cycles after reset before requests are accepted.
DATA_HOLD, 1, clk periods write data stays driven after M2 falls; must be < HALF_CYCLES.

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
req  in  1  request valid
req_rw  in  1  1=read, 0=write
req_addr  in  16  CPU address
req_wdata  in  8  write data
ready  out  1  request slot free and init done
rsp_valid  out  1  one-clk pulse when a transaction completes
rsp_rdata  out  8  read data, valid with rsp_valid
m2  out  1  M2 clock to cart
romsel  out  1  /ROMSEL, active low
cpu_rw  out  1  R/W
cpu_addr  out  15  A0-A14
cpu_data_out  out  8  data driven to cart
cpu_data_oe  out  1  data bus output enable (pad tristate)
cpu_data_in  in  8  data bus from cart

Behaviour:
- Reset is asynchronous. While rst_n=0: m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0, cpu_data_oe=0, ready=0, rsp_valid=0, rsp_rdata=0; pending slot empty; init counter reloaded with INIT_CYCLES.
- M2 cycle: low phase HALF_CYCLES clks, then high phase HALF_CYCLES clks; period is always exactly 2*HALF_CYCLES and is never stretched.
- low_start = first clk of a low phase; the first low_start follows reset release.
- Init: the first INIT_CYCLES M2 cycles are idle. ready rises on the clk after the INIT_CYCLES-th M2 falling edge.
- Idle cycle: cpu_addr=0, cpu_rw=1, romsel=1, cpu_data_oe=0, no rsp_valid.
- Handshake: the request is accepted on a clk edge where req&ready=1. It is captured into a one-entry pending slot and ready drops the next clk. ready = init_done & slot_empty.
- Issue: at low_start, a full slot is moved into the active cycle and the slot frees; ready reasserts the same clk. A request accepted on edge N is issued at the first low_start after N. This gives one transaction per M2 cycle with no idle gap when req is held high.
- Active cycle, low phase: cpu_addr=req_addr[14:0] and cpu_rw=req_rw from low_start, stable through the whole cycle; romsel=1.
- Active cycle, high phase: romsel = ~req_addr[15] for the whole high phase, and 1 otherwise.
- Write: cpu_data_oe=1 and cpu_data_out=wdata for the full high phase plus DATA_HOLD clks after M2 falls. cpu_addr and cpu_rw are held during the hold clks.
- Read: cpu_data_in is registered on the edge where m2 goes 1->0 (last high clk), giving rsp_rdata. cpu_data_oe stays 0.
- Completion: rsp_valid pulses one clk, coincident with m2 falling, for both reads and writes. On writes rsp_rdata keeps its previous value.
- Any mid-operation reset aborts immediately to the reset values. The pending request is lost without a response, and init re-runs.

Decomposition:
- Shared package famicom_bus_pkg: state enum (ST_INIT, ST_IDLE, ST_ACTIVE) and constant IDLE_ADDR=16'h0000.
- Sub-module m2_phase_gen: phase counter sized $clog2(HALF_CYCLES). It outputs m2, low_start, high_start, fall_strobe.
- The top level holds the init counter, pending slot, active registers and response logic.

Test Plan:
- Reset release, HALF_CYCLES=3 -> 16 M2 cycles of period 6 clks with romsel=1, cpu_addr=0; ready rises on the clk after the 16th M2 fall.
- Read $8123, cpu_data_in=8'hA5 -> cpu_addr=15'h0123, cpu_rw=1; romsel low only for the 3 high clks; rsp_valid one clk at M2 fall; rsp_rdata=8'hA5; cpu_data_oe never 1.
- Write $6000=8'h3C -> romsel stays 1, cpu_rw=0 for the whole cycle; cpu_data_oe=1 for 3 high clks plus 1 hold clk with cpu_data_out=8'h3C; rsp_valid pulse; rsp_rdata unchanged.
- req held high with reads $8000,$8001,$8002 -> three consecutive M2 cycles with no idle cycle between; three rsp_valid pulses 6 clks apart.
- Request asserted mid high phase -> issued at the next low_start; M2 period stays 6 clks; the intervening cycle is idle.
- rst_n low during the write high phase -> cpu_data_oe=0, romsel=1, m2=0 immediately (no clk edge); no rsp_valid; after release, 16 init cycles again before ready.
